// File: rtl/mux21_sel_arb.sv
// Two-requester round-robin arbiter driving the select line of a 2:1 mux.
// The holder keeps the grant for at most MAX_HOLD cycles while the other side waits.
module mux21_sel_arb #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  output logic             S,
  output logic             GNT0,
  output logic             GNT1,
  output logic [CNT_W-1:0] HOLD_CNT,
  output logic             SWITCH
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic             sw_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             s_nxt;

  // Next-state, burst counter and switch-pulse decode.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sw_nxt    = 1'b0;
    cnt_nxt   = HOLD_CNT;
    s_nxt     = S;
    unique case (state)
      IDLE: begin
        if (REQ0 && REQ1) state_nxt = last ? G0 : G1;
        else if (REQ0)    state_nxt = G0;
        else if (REQ1)    state_nxt = G1;
      end
      G0: begin
        if (!REQ0) begin
          if (REQ1) begin
            state_nxt = G1;
            sw_nxt    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (REQ1 && (HOLD_CNT == HOLD_LAST)) begin
          state_nxt = G1;
          sw_nxt    = 1'b1;
        end else if (HOLD_CNT != HOLD_LAST) begin
          cnt_nxt = HOLD_CNT + CNT_W'(1);
        end
      end
      G1: begin
        if (!REQ1) begin
          if (REQ0) begin
            state_nxt = G0;
            sw_nxt    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (REQ0 && (HOLD_CNT == HOLD_LAST)) begin
          state_nxt = G0;
          sw_nxt    = 1'b1;
        end else if (HOLD_CNT != HOLD_LAST) begin
          cnt_nxt = HOLD_CNT + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A fresh grant or a release restarts the burst count.
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state_nxt == G0) last_nxt = 1'b0;
      if (state_nxt == G1) last_nxt = 1'b1;
    end

    // Select only moves on a grant, so it holds through IDLE.
    if (state_nxt == G0) s_nxt = 1'b0;
    if (state_nxt == G1) s_nxt = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      last     <= 1'b1;
      S        <= 1'b0;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      HOLD_CNT <= '0;
      SWITCH   <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      S        <= s_nxt;
      GNT0     <= (state_nxt == G0);
      GNT1     <= (state_nxt == G1);
      HOLD_CNT <= cnt_nxt;
      SWITCH   <= sw_nxt;
    end
  end

endmodule

// File: tb/tb_mux21_sel_arb.sv
// Directed bench for mux21_sel_arb: a vector table walks the main scenarios,
// a second MAX_HOLD=1 instance covers per-cycle alternation.
module tb_mux21_sel_arb;

  logic       clk;
  logic       rst, req0, req1;
  logic       s, gnt0, gnt1, sw;
  logic [2:0] cnt;

  logic       rst_b, req0_b, req1_b;
  logic       s_b, gnt0_b, gnt1_b, sw_b;
  logic [0:0] cnt_b;

  logic [7:0] d0, d1;

  int tests;
  int fails;

  mux21_sel_arb #(.MAX_HOLD(4), .CNT_W(3)) u_dut (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1),
    .S(s), .GNT0(gnt0), .GNT1(gnt1), .HOLD_CNT(cnt), .SWITCH(sw)
  );

  mux21_sel_arb #(.MAX_HOLD(1), .CNT_W(1)) u_dut_h1 (
    .CLK(clk), .RST(rst_b), .REQ0(req0_b), .REQ1(req1_b),
    .S(s_b), .GNT0(gnt0_b), .GNT1(gnt1_b), .HOLD_CNT(cnt_b), .SWITCH(sw_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, r0, r1;
    logic       s, g0, g1;
    logic [2:0] cnt;
    logic       sw;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic a, input logic b,
                              input logic es, input logic eg0, input logic eg1,
                              input logic [2:0] ec, input logic esw);
    vec_t v;
    v.rst = r;  v.r0 = a;   v.r1 = b;
    v.s   = es; v.g0 = eg0; v.g1 = eg1; v.cnt = ec; v.sw = esw;
    vecs.push_back(v);
  endfunction

  // Downstream 2:1 mux fed by S must route the granted source.
  always @(negedge clk) begin
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    #1;
    if (gnt0 || gnt1) begin
      tests++;
      if ((s ? d1 : d0) != (gnt1 ? d1 : d0)) begin
        fails++;
        $display("FAIL mux_route: y=%h required=%h", (s ? d1 : d0), (gnt1 ? d1 : d0));
      end
    end
    tests++;
    if ((gnt0 && gnt1) || (gnt0_b && gnt1_b)) begin
      fails++;
      $display("FAIL onehot_gnt: gnt0=%b gnt1=%b gnt0_b=%b gnt1_b=%b required not both",
               gnt0, gnt1, gnt0_b, gnt1_b);
    end
  end

  task automatic chk_b(input string name, input logic es, input logic eg0,
                       input logic eg1, input logic esw);
    tests++;
    if ({s_b, gnt0_b, gnt1_b, sw_b} !== {es, eg0, eg1, esw}) begin
      fails++;
      $display("FAIL %s: s/g0/g1/sw=%b%b%b%b required %b%b%b%b",
               name, s_b, gnt0_b, gnt1_b, sw_b, es, eg0, eg1, esw);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0;

    //  rst r0 r1   s g0 g1 cnt sw
    // reset held with both requesting
    add(1, 1, 1,   0, 0, 0, 0, 0);
    add(1, 1, 1,   0, 0, 0, 0, 0);
    // both requesting: 4-cycle bursts alternating
    add(0, 1, 1,   0, 1, 0, 0, 0);
    add(0, 1, 1,   0, 1, 0, 1, 0);
    add(0, 1, 1,   0, 1, 0, 2, 0);
    add(0, 1, 1,   0, 1, 0, 3, 0);
    add(0, 1, 1,   1, 0, 1, 0, 1);
    add(0, 1, 1,   1, 0, 1, 1, 0);
    add(0, 1, 1,   1, 0, 1, 2, 0);
    add(0, 1, 1,   1, 0, 1, 3, 0);
    add(0, 1, 1,   0, 1, 0, 0, 1);
    // release to IDLE, then REQ1 alone for 10 cycles: saturates, no switch
    add(0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 1,   1, 0, 1, 0, 0);
    add(0, 0, 1,   1, 0, 1, 1, 0);
    add(0, 0, 1,   1, 0, 1, 2, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 1,   1, 0, 1, 3, 0);
    add(0, 0, 0,   1, 0, 0, 0, 0);
    // G0 at HOLD_CNT=1, REQ0 dropped while REQ1 waits
    add(0, 1, 0,   0, 1, 0, 0, 0);
    add(0, 1, 0,   0, 1, 0, 1, 0);
    add(0, 0, 1,   1, 0, 1, 0, 1);
    // build last=0, then tie from IDLE goes to requester 1
    add(0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 1, 0,   0, 1, 0, 0, 0);
    add(0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 1, 1,   1, 0, 1, 0, 0);
    // reset mid-burst in G1 at HOLD_CNT=2, then tie restarts at G0
    add(0, 1, 1,   1, 0, 1, 1, 0);
    add(0, 1, 1,   1, 0, 1, 2, 0);
    add(1, 1, 1,   0, 0, 0, 0, 0);
    add(0, 1, 1,   0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req0 = vecs[i].r0; req1 = vecs[i].r1;
      @(posedge clk);
      #1;
      tests++;
      if ({s, gnt0, gnt1, cnt, sw} !== {vecs[i].s, vecs[i].g0, vecs[i].g1, vecs[i].cnt, vecs[i].sw}) begin
        fails++;
        $display("FAIL vec%0d: s=%b g0=%b g1=%b cnt=%0d sw=%b required s=%b g0=%b g1=%b cnt=%0d sw=%b",
                 i, s, gnt0, gnt1, cnt, sw,
                 vecs[i].s, vecs[i].g0, vecs[i].g1, vecs[i].cnt, vecs[i].sw);
      end
    end

    // MAX_HOLD=1: grant flips every cycle and SWITCH stays high
    @(negedge clk);
    rst_b = 1'b0; req0_b = 1'b1; req1_b = 1'b1;
    @(posedge clk); #1; chk_b("h1_first", 0, 1, 0, 0);
    @(posedge clk); #1; chk_b("h1_alt1",  1, 0, 1, 1);
    @(posedge clk); #1; chk_b("h1_alt2",  0, 1, 0, 1);
    @(posedge clk); #1; chk_b("h1_alt3",  1, 0, 1, 1);
    @(negedge clk);
    req0_b = 1'b0;
    @(posedge clk); #1; chk_b("h1_stay",  1, 0, 1, 0);
    @(negedge clk);
    req1_b = 1'b0;
    @(posedge clk); #1; chk_b("h1_idle",  1, 0, 0, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
